// File: rtl/hba_fifo_slave.sv
// rtl/hba_fifo_slave.sv - HBA register slave fronting a circular FIFO (DATA/STATUS/COUNT/CTRL regs).
// Optional threshold interrupt and THRESH register enabled by macro HBA_FIFO_IRQ_EN.
module hba_fifo_slave #(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int PERIPH_ADDR       = 2,
   parameter int FIFO_DEPTH_LOG2   = 4
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  hba_rnw,
   input  logic                  hba_select,
   input  logic [ADDR_WIDTH-1:0] hba_abus,
   input  logic [DBUS_WIDTH-1:0] hba_dbus,
   output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  hba_xferack_slave,
   output logic                  fifo_interrupt
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;

   logic [DBUS_WIDTH-1:0]      r_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wptr, r_rptr;
   logic [CW-1:0]              r_count;
   logic                       r_ovf, r_unf;
   logic                       r_ack;
   logic [DBUS_WIDTH-1:0]      r_dbus;
   // Cleared by reset; re-arms only once select is seen low, so a transfer
   // interrupted by reset is never acknowledged after release.
   logic                       r_armed;

   logic [REG_ADDR_WIDTH-1:0] w_reg;
   logic w_hit, w_do, w_full, w_empty;
   logic w_is_data, w_is_stat, w_is_cnt, w_is_ctrl, w_is_thr;
   logic w_push, w_pop, w_flush, w_clr, w_set_ovf, w_set_unf;
   logic [DBUS_WIDTH-1:0] w_rdata, w_thresh_rd;

   assign w_reg     = hba_abus[REG_ADDR_WIDTH-1:0];
   assign w_hit     = hba_select &&
                      (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == (ADDR_WIDTH-REG_ADDR_WIDTH)'(PERIPH_ADDR));
   assign w_do      = w_hit && !r_ack && r_armed;
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_is_data = (w_reg == REG_ADDR_WIDTH'(0));
   assign w_is_stat = (w_reg == REG_ADDR_WIDTH'(1));
   assign w_is_cnt  = (w_reg == REG_ADDR_WIDTH'(2));
   assign w_is_ctrl = (w_reg == REG_ADDR_WIDTH'(3));

   assign w_push    = w_do && !hba_rnw && w_is_data && !w_full;
   assign w_pop     = w_do &&  hba_rnw && w_is_data && !w_empty;
   assign w_set_ovf = w_do && !hba_rnw && w_is_data &&  w_full;
   assign w_set_unf = w_do &&  hba_rnw && w_is_data &&  w_empty;
   assign w_flush   = w_do && !hba_rnw && w_is_ctrl && hba_dbus[0];
   assign w_clr     = w_do && !hba_rnw && w_is_ctrl && hba_dbus[1];

`ifdef HBA_FIFO_IRQ_EN
   logic [DBUS_WIDTH-1:0] r_thresh;
   logic                  r_irq;

   assign w_is_thr    = (w_reg == REG_ADDR_WIDTH'(4));
   assign w_thresh_rd = r_thresh;
   assign fifo_interrupt = r_irq;

   always_ff @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset) begin
         r_thresh <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_do && !hba_rnw && w_is_thr)
            r_thresh <= hba_dbus;
         r_irq <= ((r_thresh != '0) && (32'(r_count) >= 32'(r_thresh))) || r_ovf;
      end
   end
`else
   assign w_is_thr       = 1'b0;
   assign w_thresh_rd    = '0;
   assign fifo_interrupt = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      if (w_is_data && !w_empty)
         w_rdata = r_mem[r_rptr];
      else if (w_is_stat)
         w_rdata = DBUS_WIDTH'({r_unf, r_ovf, w_full, w_empty});
      else if (w_is_cnt)
         w_rdata = DBUS_WIDTH'(r_count);
      else if (w_is_thr)
         w_rdata = w_thresh_rd;
   end

   always_ff @(posedge hba_clk) begin
      if (w_push)
         r_mem[r_wptr] <= hba_dbus;
   end

   always_ff @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_ack   <= 1'b0;
         r_dbus  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_armed <= r_armed | ~hba_select;
         r_ack   <= w_do;
         r_dbus  <= (w_do && hba_rnw) ? w_rdata : '0;
         if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push)     r_count <= r_count + 1'b1;
            else if (w_pop) r_count <= r_count - 1'b1;
         end
         if (w_clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end else begin
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
         end
      end
   end

   assign hba_xferack_slave = r_ack;
   assign hba_dbus_slave    = r_dbus;

endmodule

// File: tb/tb_hba_fifo_slave.sv
// tb/tb_hba_fifo_slave.sv - scoreboard bench for hba_fifo_slave against a queue-based FIFO model.
module tb_hba_fifo_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rnw = 1'b0;
   logic        sel = 1'b0;
   logic [11:0] abus = '0;
   logic [7:0]  dbus = '0;
   logic [7:0]  dbus_slave;
   logic        ack;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;

   logic [7:0] sb[$];

   logic [7:0] mq[$];
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;
   int         m_thresh = 0;

   hba_fifo_slave dut (
      .hba_clk          (clk),
      .hba_reset        (rst),
      .hba_rnw          (rnw),
      .hba_select       (sel),
      .hba_abus         (abus),
      .hba_dbus         (dbus),
      .hba_dbus_slave   (dbus_slave),
      .hba_xferack_slave(ack),
      .fifo_interrupt   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_thresh = 0;
   endfunction

   function automatic logic [7:0] model_acc(input bit rd, input int r, input logic [7:0] wd);
      logic [7:0] v;
      v = 8'h00;
      case (r)
         0: begin
            if (!rd) begin
               if (mq.size() == 16) m_ovf = 1'b1;
               else mq.push_back(wd);
            end else begin
               if (mq.size() == 0) m_unf = 1'b1;
               else v = mq.pop_front();
            end
         end
         1: if (rd) v = {4'h0, m_unf, m_ovf, mq.size() == 16, mq.size() == 0};
         2: if (rd) v = 8'(mq.size());
         3: if (!rd) begin
               if (wd[0]) mq.delete();
               if (wd[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
            end
`ifdef HBA_FIFO_IRQ_EN
         4: begin
            if (rd) v = 8'(m_thresh);
            else m_thresh = int'(wd);
         end
`endif
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic bit model_irq();
`ifdef HBA_FIFO_IRQ_EN
      return ((m_thresh != 0) && (mq.size() >= m_thresh)) || m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   // One transfer, then one idle cycle so the registered interrupt settles.
   task automatic xfer(input bit rd, input logic [3:0] per, input int r, input logic [7:0] wd);
      bit got;
      got = 1'b0;
      if (per == 4'd2) sb.push_back(model_acc(rd, r, wd));
      @(posedge clk); #1;
      rnw = rd; abus = {per, 8'(r)}; dbus = wd; sel = 1'b1;
      if (per == 4'd2) begin
         for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
         end
         if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout: reg %0d got no ack expected ack", r);
            void'(sb.pop_back());
         end
      end else begin
         repeat (4) @(posedge clk);
         #1;
      end
      sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0;
      @(posedge clk); #1;
      check("irq", int'(irq), int'(model_irq()));
   endtask

   task automatic wr(input int r, input logic [7:0] d); xfer(1'b0, 4'd2, r, d); endtask
   task automatic rd(input int r);                      xfer(1'b1, 4'd2, r, 8'h00); endtask

   // Monitor: every ack pops one expected read value; ack must be one cycle wide.
   initial begin
      bit prev_ack;
      logic [7:0] e;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            n_checks++;
            if (ack !== 1'b0 || dbus_slave !== 8'h00 || irq !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_outputs: got ack=%b data=0x%0h irq=%b expected 0", ack, dbus_slave, irq);
            end
            prev_ack = 1'b0;
         end else begin
            if (ack) begin
               ack_cnt++;
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_ack: got ack with data 0x%0h expected none", dbus_slave);
               end else begin
                  e = sb.pop_front();
                  if (dbus_slave !== e) begin
                     n_fail++;
                     $display("FAIL read_data: got 0x%0h expected 0x%0h", dbus_slave, e);
                  end
               end
               n_checks++;
               if (prev_ack) begin
                  n_fail++;
                  $display("FAIL ack_width: got ack high 2 cycles expected 1");
               end
            end else begin
               n_checks++;
               if (dbus_slave !== 8'h00) begin
                  n_fail++;
                  $display("FAIL idle_data: got 0x%0h expected 0x00", dbus_slave);
               end
            end
            prev_ack = ack;
         end
      end
   end

   initial begin
      int a0, r, d;
      bit rdb;
      logic [3:0] per;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rd(1);
      rd(2);

      wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
      rd(2);
      rd(0); rd(0); rd(0);
      rd(2); rd(1);

      for (int i = 0; i <= 16; i++) wr(0, 8'(i));
      rd(2); rd(1);
      for (int i = 0; i < 16; i++) rd(0);

      wr(3, 8'h02);
      rd(0);
      rd(1);
      wr(3, 8'h02);
      rd(1);

      for (int i = 0; i < 12; i++) wr(0, 8'(8'h50 + i));
      for (int i = 0; i < 12; i++) rd(0);
      for (int i = 0; i < 8; i++) wr(0, 8'(8'hA0 + i));
      for (int i = 0; i < 8; i++) rd(0);

      a0 = ack_cnt;
      xfer(1'b1, 4'd3, 0, 8'h00);
      check("nohit_acks", ack_cnt - a0, 0);
      a0 = ack_cnt;
      rd(0);
      check("hit_acks", ack_cnt - a0, 1);
      wr(7, 8'hFF);
      rd(7);
      rd(4);

`ifdef HBA_FIFO_IRQ_EN
      wr(3, 8'h03);
      wr(4, 8'h04);
      rd(4);
      wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03);
      check("irq_below_thresh", int'(irq), 0);
      wr(0, 8'h04);
      check("irq_at_thresh", int'(irq), 1);
      rd(0);
      check("irq_after_read", int'(irq), 0);
`endif

      @(posedge clk); #1;
      rnw = 1'b0; abus = 12'h200; dbus = 8'h55; sel = 1'b1;
      #2 rst = 1'b1;
      model_reset();
      a0 = ack_cnt;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_abort_acks", ack_cnt - a0, 0);
      sel = 1'b0; abus = '0; dbus = '0;
      rd(2);
      rd(1);

      for (int n = 0; n < 300; n++) begin
         r   = $urandom_range(0, 5);
         if (r == 3 && $urandom_range(0, 3) != 0) r = 0;
         rdb = 1'($urandom_range(0, 1));
         d   = $urandom_range(0, 255);
         if (r == 4 && !rdb) d = $urandom_range(0, 17);
         per = ($urandom_range(0, 19) == 0) ? 4'd3 : 4'd2;
         xfer(rdb, per, r, 8'(d));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hba_fifo_slave.md
HBA_FIFO_SLAVE -- requirements
Module: hba_fifo_slave

Interface
REQ-001 The block SHALL take parameter DBUS_WIDTH, default 8, as the HBA data bus width.
REQ-002 The block SHALL take parameter PERIPH_ADDR_WIDTH, default 4, as the peripheral-select field width.
REQ-003 The block SHALL take parameter REG_ADDR_WIDTH, default 8, as the register-offset field width.
REQ-004 The block SHALL take parameter ADDR_WIDTH, default PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, as the address bus width.
REQ-005 The block SHALL take parameter PERIPH_ADDR, default 2, as this slave's peripheral slot number.
REQ-006 The block SHALL take parameter FIFO_DEPTH_LOG2, default 4, as log2 of the FIFO depth (depth 16).
REQ-007 The block SHALL have port hba_clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port hba_reset, input, 1, the reset; it is asynchronous and active-high.
REQ-009 The block SHALL have port hba_rnw, input, 1, where 1=read and 0=write.
REQ-010 The block SHALL have port hba_select, input, 1, which is high while a transfer is in progress.
REQ-011 The block SHALL have port hba_abus, input, ADDR_WIDTH, the transfer address.
REQ-012 The block SHALL have port hba_dbus, input, DBUS_WIDTH, the write data.
REQ-013 The block SHALL have port hba_dbus_slave, output, DBUS_WIDTH, the read data; it is zero whenever hba_xferack_slave is low.
REQ-014 The block SHALL have port hba_xferack_slave, output, 1, the transfer-complete acknowledge; it is zero when inactive.
REQ-015 The block SHALL have port fifo_interrupt, output, 1, the level interrupt.

Function
REQ-016 The block SHALL decode a hit as hba_select=1 and hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]=PERIPH_ADDR, with reg = hba_abus[REG_ADDR_WIDTH-1:0].
REQ-017 On a hit with hba_xferack_slave=0, the block SHALL register hba_xferack_slave=1 for exactly one cycle on the next edge; on the following edge it SHALL return to 0 even if hba_select is still high.
REQ-018 The block SHALL perform the register side-effect (push, pop, control) on the same edge that raises hba_xferack_slave, and SHALL present read data registered on that edge.
REQ-019 Reg 0 DATA: a write SHALL push hba_dbus; a read SHALL return the head entry and pop it.
REQ-020 Reg 1 STATUS (read-only): the block SHALL map bit0 to empty, bit1 to full, bit2 to sticky overflow, bit3 to sticky underflow, and bits 7:4 to 0.
REQ-021 Reg 2 COUNT (read-only): the block SHALL return the occupancy 0..2^FIFO_DEPTH_LOG2, zero-extended to DBUS_WIDTH.
REQ-022 Reg 3 CTRL (write-only, reads 0): on a write, bit0=1 SHALL flush (pointers and count to 0) and bit1=1 SHALL clear both sticky flags; the bits are self-clearing.
REQ-023 The block SHALL keep the FIFO as circular storage with read and write pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth, and a count of FIFO_DEPTH_LOG2+1 bits.
REQ-024 A write to DATA while full SHALL be dropped, leave pointers and count unchanged, set overflow, and still be acknowledged.
REQ-025 A read of DATA while empty SHALL return 0, leave pointers unchanged, set underflow, and be acknowledged.
REQ-026 On a CTRL write with bit0=1 and bit1=1, the block SHALL flush and clear both sticky flags in the same cycle.
REQ-027 The block SHALL acknowledge accesses to unmapped registers, ignore writes to them, and return 0 on reads.
REQ-028 The block SHALL NOT respond when the peripheral field mismatches: hba_xferack_slave and hba_dbus_slave stay 0.

Reset
REQ-029 While hba_reset=1, the block SHALL hold hba_xferack_slave=0, hba_dbus_slave=0, pointers=0, count=0, sticky flags=0, fifo_interrupt=0 and threshold=0, asynchronously.
REQ-030 Reset asserted mid-transfer SHALL abort it with no push or pop, and no acknowledge SHALL be issued for it after release.

Configuration
REQ-031 With macro HBA_FIFO_IRQ_EN defined, reg 4 THRESH SHALL be read/write (reset 0), and fifo_interrupt SHALL be registered as (THRESH!=0 and count>=THRESH) or overflow.
REQ-032 Without HBA_FIFO_IRQ_EN, reg 4 SHALL behave as unmapped and fifo_interrupt SHALL be constant 0.

Verification
REQ-033 The bench SHALL check: write 0x11,0x22,0x33 to DATA, then read DATA three times -> 0x11,0x22,0x33; COUNT 3 then 0; STATUS 0x01 after.
REQ-034 The bench SHALL check: 17 writes 0x00..0x10 -> COUNT=16, STATUS=0x06; 16 reads return 0x00..0x0F (0x10 lost).
REQ-035 The bench SHALL check: read DATA while empty -> data 0x00, ack exactly 1 cycle, STATUS=0x09; CTRL write 0x02 -> STATUS=0x01.
REQ-036 The bench SHALL check: 12 writes, 12 reads, then 8 writes 0xA0..0xA7 (pointer wrap) -> reads return 0xA0..0xA7 in order.
REQ-037 The bench SHALL check: with PERIPH_ADDR=2, hba_select held 4 cycles on abus 0x300 -> no ack, dbus_slave 0; on abus 0x200 -> a single one-cycle ack.
REQ-038 With HBA_FIFO_IRQ_EN, the bench SHALL check: THRESH=4 and 3 writes -> fifo_interrupt=0; 4th write -> 1; one read -> 0; reset mid-write -> no ack and count 0.
